// File: rtl/clean_beats_nios2_div_cell_if.sv
// Start/busy/done bundle between the A-stage and the divider cell.
// The requester drives start and operands; the cell returns status and results.
interface clean_beats_nios2_div_cell_if #(
    parameter int WIDTH = 32
) ();
    logic             A_div_start;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quot;
    logic [WIDTH-1:0] A_div_rem;
    logic             A_div_by_zero;

    // start is taken only while the cell is idle; done is a one-cycle pulse
    // and quot/rem/by_zero stay valid from that cycle until the next done.
    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed,
        input  A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed,
        output A_div_busy, A_div_done, A_div_quot, A_div_rem, A_div_by_zero
    );
endinterface

// File: rtl/clean_beats_nios2_div_cell.sv
// Radix-2 restoring divider, one quotient bit per clock, fixed WIDTH+2 cycle latency.
// Signed support is built only when CLEAN_BEATS_DIV_SIGNED_EN is defined.
module clean_beats_nios2_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    clean_beats_nios2_div_cell_if.slave   bus,
    output logic [1:0]                    dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             by_zero_q, by_zero_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] mag1, mag2;

`ifdef CLEAN_BEATS_DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
`else
    logic signed_unused;
    assign signed_unused = bus.A_div_signed;
`endif

    // Quotient bits shift into the low end of dvd as the dividend shifts out.
    assign shifted = {prem_q, dvd_q[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});
    assign trial   = shifted[WIDTH-1:0] - dvs_q;

`ifdef CLEAN_BEATS_DIV_SIGNED_EN
    assign mag1 = (bus.A_div_signed && bus.A_div_src1[WIDTH-1]) ? -bus.A_div_src1 : bus.A_div_src1;
    assign mag2 = (bus.A_div_signed && bus.A_div_src2[WIDTH-1]) ? -bus.A_div_src2 : bus.A_div_src2;
`else
    assign mag1 = bus.A_div_src1;
    assign mag2 = bus.A_div_src2;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        src1_d    = src1_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        by_zero_d = by_zero_q;
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.A_div_start) begin
                    dvd_d   = mag1;
                    dvs_d   = mag2;
                    src1_d  = bus.A_div_src1;
                    zero_d  = (bus.A_div_src2 == '0);
                    prem_d  = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
                    neg_quot_d = bus.A_div_signed && (bus.A_div_src1[WIDTH-1] ^ bus.A_div_src2[WIDTH-1]);
                    neg_rem_d  = bus.A_div_signed && bus.A_div_src1[WIDTH-1];
`endif
                end
            end
            S_CALC: begin
                prem_d = fits ? trial : shifted[WIDTH-1:0];
                dvd_d  = {dvd_q[WIDTH-2:0], fits};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
                quot_d = neg_quot_q ? -dvd_q : dvd_q;
                rem_d  = neg_rem_q ? -prem_q : prem_q;
`else
                quot_d = dvd_q;
                rem_d  = prem_q;
`endif
                // A zero divisor reports the raw dividend, not its magnitude.
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = src1_q;
                end
                by_zero_d = zero_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            src1_q    <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            by_zero_q <= 1'b0;
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            src1_q    <= src1_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            by_zero_q <= by_zero_d;
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign bus.A_div_busy    = busy_q;
    assign bus.A_div_done    = done_q;
    assign bus.A_div_quot    = quot_q;
    assign bus.A_div_rem     = rem_q;
    assign bus.A_div_by_zero = by_zero_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_clean_beats_nios2_div_cell.sv
// Directed bench for the divider cell: latency, results, zero divisor, handshake and reset.
module tb_clean_beats_nios2_div_cell;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;
    int         edges;
    int         done_seen;

    clean_beats_nios2_div_cell_if #(.WIDTH(32)) bus ();

    clean_beats_nios2_div_cell #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns just after the accepting edge (edge 1).
    task automatic issue(input logic [31:0] s1, input logic [31:0] s2, input logic sg);
        @(negedge clk);
        bus.A_div_src1   = s1;
        bus.A_div_src2   = s2;
        bus.A_div_signed = sg;
        bus.A_div_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.A_div_start = 1'b0;
    endtask

    task automatic wait_done(output int e);
        e = 1;
        while (bus.A_div_done !== 1'b1 && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.A_div_start  = 1'b0;
        bus.A_div_src1   = '0;
        bus.A_div_src2   = '0;
        bus.A_div_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.A_div_busy), 32'd0);
        chk("rst_done", 32'(bus.A_div_done), 32'd0);
        chk("rst_quot", bus.A_div_quot, 32'd0);
        chk("rst_rem", bus.A_div_rem, 32'd0);
        chk("rst_bz", 32'(bus.A_div_by_zero), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 100 / 7 unsigned
        issue(32'd100, 32'd7, 1'b0);
        chk("t1_busy", 32'(bus.A_div_busy), 32'd1);
        wait_done(edges);
        chk("t1_lat", 32'(edges), 32'd34);
        chk("t1_quot", bus.A_div_quot, 32'd14);
        chk("t1_rem", bus.A_div_rem, 32'd2);
        chk("t1_bz", 32'(bus.A_div_by_zero), 32'd0);

        // -100 / 7 with signed requested
        issue(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_done(edges);
        chk("t2_lat", 32'(edges), 32'd34);
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
        chk("t2_quot", bus.A_div_quot, 32'hFFFF_FFF2);
        chk("t2_rem", bus.A_div_rem, 32'hFFFF_FFFE);
`else
        chk("t2_quot", bus.A_div_quot, 32'h2492_4916);
        chk("t2_rem", bus.A_div_rem, 32'h0000_0002);
`endif

        // most-negative / -1
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(edges);
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
        chk("t3_quot", bus.A_div_quot, 32'h8000_0000);
        chk("t3_rem", bus.A_div_rem, 32'h0000_0000);
`else
        chk("t3_quot", bus.A_div_quot, 32'h0000_0000);
        chk("t3_rem", bus.A_div_rem, 32'h8000_0000);
`endif
        chk("t3_bz", 32'(bus.A_div_by_zero), 32'd0);

        // 100 / -7
        issue(32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_done(edges);
`ifdef CLEAN_BEATS_DIV_SIGNED_EN
        chk("t3b_quot", bus.A_div_quot, 32'hFFFF_FFF2);
        chk("t3b_rem", bus.A_div_rem, 32'd2);
`else
        chk("t3b_quot", bus.A_div_quot, 32'd0);
        chk("t3b_rem", bus.A_div_rem, 32'd100);
`endif

        // zero divisor, then hold
        issue(32'd5, 32'd0, 1'b0);
        wait_done(edges);
        chk("t4_lat", 32'(edges), 32'd34);
        chk("t4_quot", bus.A_div_quot, 32'hFFFF_FFFF);
        chk("t4_rem", bus.A_div_rem, 32'd5);
        chk("t4_bz", 32'(bus.A_div_by_zero), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_done_pulse", 32'(bus.A_div_done), 32'd0);
        chk("t4_hold_quot", bus.A_div_quot, 32'hFFFF_FFFF);
        chk("t4_hold_rem", bus.A_div_rem, 32'd5);
        chk("t4_hold_bz", 32'(bus.A_div_by_zero), 32'd1);

        // signed zero divisor keeps the raw dividend
        issue(32'hFFFF_FFFB, 32'd0, 1'b1);
        wait_done(edges);
        chk("t4b_quot", bus.A_div_quot, 32'hFFFF_FFFF);
        chk("t4b_rem", bus.A_div_rem, 32'hFFFF_FFFB);
        chk("t4b_bz", 32'(bus.A_div_by_zero), 32'd1);

        // start held high; operands change before edge 10
        @(negedge clk);
        bus.A_div_src1   = 32'd1000;
        bus.A_div_src2   = 32'd10;
        bus.A_div_signed = 1'b0;
        bus.A_div_start  = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        while (bus.A_div_done !== 1'b1 && edges < 100) begin
            if (edges == 9) begin
                bus.A_div_src1 = 32'd77;
                bus.A_div_src2 = 32'd5;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk("t5_lat1", 32'(edges), 32'd34);
        chk("t5_quot1", bus.A_div_quot, 32'd100);
        chk("t5_rem1", bus.A_div_rem, 32'd0);
        @(posedge clk);
        #1;
        bus.A_div_start = 1'b0;
        chk("t5_busy2", 32'(bus.A_div_busy), 32'd1);
        wait_done(edges);
        chk("t5_lat2", 32'(edges), 32'd34);
        chk("t5_quot2", bus.A_div_quot, 32'd15);
        chk("t5_rem2", bus.A_div_rem, 32'd2);

        // reset at edge 12 of an op
        issue(32'd1000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_busy", 32'(bus.A_div_busy), 32'd0);
        chk("t6_quot", bus.A_div_quot, 32'd0);
        chk("t6_rem", bus.A_div_rem, 32'd0);
        chk("t6_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.A_div_done === 1'b1) done_seen++;
        end
        chk("t6_no_done", 32'(done_seen), 32'd0);
        issue(32'd1000, 32'd3, 1'b0);
        wait_done(edges);
        chk("t6_lat", 32'(edges), 32'd34);
        chk("t6_quot2", bus.A_div_quot, 32'd333);
        chk("t6_rem2", bus.A_div_rem, 32'd1);

        // reset and start together: start is dropped
        @(negedge clk);
        reset           = 1'b1;
        bus.A_div_start = 1'b1;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.A_div_start = 1'b0;
        chk("t7_busy_a", 32'(bus.A_div_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("t7_busy_b", 32'(bus.A_div_busy), 32'd0);
        chk("t7_state", 32'(dbg_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
